// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit x^4+x^3+1 PRBS lock checker.
package lfsr_pkg;

  localparam int HIST_W = 4;
  localparam int TAP_A  = 3;
  localparam int TAP_B  = 2;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic lfsr_pred(input logic [HIST_W-1:0] hist);
    return hist[TAP_A] ^ hist[TAP_B];
  endfunction

endpackage

// File: rtl/prbs_predict.sv
// Bit history of the incoming PRBS and the next-bit prediction from its taps.
module prbs_predict
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              bit_in,
  output logic [HIST_W-1:0] hist,
  output logic              pred
);

  logic [HIST_W-1:0] r_hist;

  // hist[0] holds the newest bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
    end else if (shift) begin
      r_hist <= {r_hist[HIST_W-2:0], bit_in};
    end
  end

  assign hist = r_hist;
  assign pred = lfsr_pred(r_hist);

endmodule

// File: rtl/lfsr_checker.sv
// Serial PRBS checker: fills a history, verifies predictions until lock, then
// flywheels the sequence and counts bit errors while locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT    = 8,
  parameter int UNLOCK_ERRS = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int FILL_W  = $clog2(HIST_W + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_ERRS + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(HIST_W - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_ERRS - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  state_t             r_state;
  logic [FILL_W-1:0]  r_fill;
  logic [MATCH_W-1:0] r_match;
  logic [MISS_W-1:0]  r_miss;
  logic               r_locked;
  logic               r_err_pulse;
  logic [CNT_W-1:0]   r_err_count;

  logic [HIST_W-1:0]  w_hist;
  logic               w_pred;
  logic               w_bit_in;
  logic               w_match;
  logic               w_hist_nz;

  // Once locked the history follows its own prediction, so line errors
  // never corrupt the reference.
  assign w_bit_in  = (r_state == ST_LOCKED) ? w_pred : din;
  assign w_match   = (din == w_pred);
  assign w_hist_nz = |w_hist;

  prbs_predict u_predict (
    .clk    (clk),
    .rst    (rst),
    .shift  (din_valid),
    .bit_in (w_bit_in),
    .hist   (w_hist),
    .pred   (w_pred)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_HUNT;
      r_fill      <= '0;
      r_match     <= '0;
      r_miss      <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (din_valid) begin
        case (r_state)
          ST_HUNT: begin
            if (r_fill == FILL_LAST) begin
              r_state <= ST_CHECK;
              r_fill  <= '0;
              r_match <= '0;
            end else begin
              r_fill <= r_fill + FILL_W'(1);
            end
          end

          // An all-zero history predicts zero forever, so it never counts
          ST_CHECK: begin
            if (w_match && w_hist_nz) begin
              if (r_match == MATCH_LAST) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_match  <= '0;
                r_miss   <= '0;
              end else begin
                r_match <= r_match + MATCH_W'(1);
              end
            end else begin
              r_match <= '0;
            end
          end

          ST_LOCKED: begin
            if (!w_match) begin
              r_err_pulse <= 1'b1;
              r_match     <= '0;
              if (r_err_count != CNT_MAX) begin
                r_err_count <= r_err_count + CNT_W'(1);
              end
              if (r_miss == MISS_LAST) begin
                r_state  <= ST_HUNT;
                r_locked <= 1'b0;
                r_fill   <= '0;
                r_miss   <= '0;
              end else begin
                r_miss <= r_miss + MISS_W'(1);
              end
            end else if (r_match == MATCH_LAST) begin
              r_match <= '0;
              r_miss  <= '0;
            end else begin
              r_match <= r_match + MATCH_W'(1);
            end
          end

          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
            r_fill   <= '0;
          end
        endcase
      end
      // clear wins over a same-cycle count; the pulse above is unaffected
      if (clear) begin
        r_err_count <= '0;
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model.
module tb_lfsr_checker;

  localparam int LOCK_CNT    = 8;
  localparam int UNLOCK_ERRS = 3;
  localparam int CNT_W       = 8;
  localparam int CNT_MAX     = 255;

  localparam int M_HUNT  = 0;
  localparam int M_CHECK = 1;
  localparam int M_LOCK  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             din_valid;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc_msgs = 0;

  // Behavioural model: protocol phase, counters, last four bits (m_h[0] oldest)
  int m_mode, m_fill, m_match, m_miss, m_run, m_count;
  bit m_pulse;
  bit m_h [4];

  // Upstream period-15 sequence from seed 1000
  bit seq_tbl [15] = '{1,0,0,1,1,0,1,0,1,1,1,1,0,0,0};
  int pos = 0;

  always #5 clk = ~clk;

  lfsr_checker #(
    .LOCK_CNT    (LOCK_CNT),
    .UNLOCK_ERRS (UNLOCK_ERRS),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0d", name, act);
    end
  endtask

  task automatic model_reset();
    m_mode = M_HUNT; m_fill = 0; m_match = 0; m_miss = 0; m_run = 0;
    m_count = 0; m_pulse = 0;
    for (int i = 0; i < 4; i++) m_h[i] = 0;
  endtask

  // Drive one cycle; the model advances on the same rising edge as the DUT
  task automatic step(input bit v, input bit d, input bit c);
    int mode, fill, match, miss, run, cnt;
    bit pulse, p, nz, nb;
    bit h [4];
    din_valid = v; din = d; clear = c;
    mode = m_mode; fill = m_fill; match = m_match; miss = m_miss;
    run = m_run; cnt = m_count; h = m_h;
    pulse = 0;
    if (v) begin
      p  = h[0] ^ h[1];
      nz = h[0] | h[1] | h[2] | h[3];
      nb = (mode == M_LOCK) ? p : d;
      if (mode == M_HUNT) begin
        fill++;
        if (fill == 4) begin mode = M_CHECK; fill = 0; match = 0; end
      end else if (mode == M_CHECK) begin
        match = (d == p && nz) ? match + 1 : 0;
        if (match == LOCK_CNT) begin mode = M_LOCK; miss = 0; run = 0; end
      end else begin
        if (d != p) begin
          pulse = 1;
          if (cnt < CNT_MAX) cnt++;
          miss++;
          run = 0;
          if (miss == UNLOCK_ERRS) begin mode = M_HUNT; fill = 0; miss = 0; end
        end else begin
          run++;
          if (run >= LOCK_CNT) miss = 0;
        end
      end
      h[0] = h[1]; h[1] = h[2]; h[2] = h[3]; h[3] = nb;
    end
    if (c) cnt = 0;
    @(posedge clk);
    m_mode = mode; m_fill = fill; m_match = match; m_miss = miss;
    m_run = run; m_count = cnt; m_pulse = pulse; m_h = h;
    #1;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, seq_tbl[pos % 15], 1'b0);
      pos++;
    end
  endtask

  task automatic bad(input bit c);
    step(1'b1, !seq_tbl[pos % 15], c);
    pos++;
  endtask

  task automatic gap_clean(input int n);
    for (int i = 0; i < n; i++) begin
      clean(1);
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic do_reset(input string tag);
    din_valid = 1'b0; clear = 1'b0; din = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_pulse"},  int'(err_pulse), 0);
    chk({tag, "_count"},  int'(err_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    n_tests++;
    if (locked !== (m_mode == M_LOCK) || err_pulse !== m_pulse ||
        err_count !== CNT_W'(m_count)) begin
      n_fail++;
      if (n_cyc_msgs < 20) begin
        n_cyc_msgs++;
        $display("FAIL cycle t=%0t: locked %b want %0d, err_pulse %b want %0d, err_count %0d want %0d",
                 $time, locked, (m_mode == M_LOCK), err_pulse, m_pulse, err_count, m_count);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit v, d, c, e;
    rst = 1'b1; din_valid = 1'b0; din = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_locked", int'(locked), 0);
    chk("reset_pulse",  int'(err_pulse), 0);
    chk("reset_count",  int'(err_count), 0);
    rst = 1'b0;

    // Clean stream: lock one cycle after the 12th bit
    clean(11);
    chk("clean_locked_after_11", int'(locked), 0);
    clean(1);
    chk("clean_locked_after_12", int'(locked), 1);
    clean(48);
    chk("clean_count_after_60", int'(err_count), 0);
    chk("clean_locked_after_60", int'(locked), 1);

    // Single bit error while locked
    bad(1'b0);
    chk("single_pulse", int'(err_pulse), 1);
    chk("single_count", int'(err_count), 1);
    chk("single_locked", int'(locked), 1);
    clean(1);
    chk("single_pulse_drop", int'(err_pulse), 0);
    clean(9);
    chk("single_count_hold", int'(err_count), 1);

    // Loss of lock after three errors inside eight bits
    step(1'b0, 1'b0, 1'b1);
    chk("clear_idle", int'(err_count), 0);
    bad(1'b0); clean(2); bad(1'b0); clean(1);
    chk("loss_locked_before_3rd", int'(locked), 1);
    bad(1'b0);
    chk("loss_locked", int'(locked), 0);
    chk("loss_count", int'(err_count), 3);
    clean(11);
    chk("relock_after_11", int'(locked), 0);
    clean(1);
    chk("relock_after_12", int'(locked), 1);

    // Mid-stream reset while locked, then gapless relock
    clean(5);
    do_reset("midrst");
    clean(11);
    chk("rst_relock_after_11", int'(locked), 0);
    clean(1);
    chk("rst_relock_after_12", int'(locked), 1);

    // Gapped stream with valid toggling 1,0,1,0
    do_reset("gaprst");
    gap_clean(11);
    chk("gap_locked_after_11", int'(locked), 0);
    clean(1);
    chk("gap_locked_after_12", int'(locked), 1);
    step(1'b0, 1'b1, 1'b0);
    bad(1'b0);
    chk("gap_err_count", int'(err_count), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("gap_idle_pulse", int'(err_pulse), 0);
    chk("gap_idle_count", int'(err_count), 1);
    bad(1'b1);
    chk("clear_err_count", int'(err_count), 0);
    chk("clear_err_pulse", int'(err_pulse), 1);
    step(1'b0, 1'b0, 1'b0);
    gap_clean(10);
    chk("gap_still_locked", int'(locked), 1);

    // All-zero stream never locks
    do_reset("zerorst");
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b0);
    chk("zero_locked", int'(locked), 0);
    chk("zero_count", int'(err_count), 0);

    // Saturation: repeated loss and relock accumulates 258 errors
    do_reset("satrst");
    clean(12);
    for (int k = 0; k < 86; k++) begin
      bad(1'b0); bad(1'b0); bad(1'b0);
      clean(12);
    end
    chk("sat_count", int'(err_count), CNT_MAX);
    chk("sat_locked", int'(locked), 1);

    // Randomized traffic against the model
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        for (int j = 0; j < 20; j++) step(1'b1, 1'b0, 1'b0);
      end else if ($urandom_range(0, 599) == 0) begin
        do_reset("rand_rst");
      end
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 15) == 0);
      if (v) begin
        d = seq_tbl[pos % 15] ^ e;
        pos++;
      end else begin
        d = 1'($urandom_range(0, 1));
      end
      step(v, d, c);
    end

    step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
